cache_arbiter: RTL
==================

# cache_arbiter

Arbiter that shares one next-level cache port between NREQ upstream cache controllers, e.g. split L1 instruction and data caches feeding a unified L2. It grants the shared port to one requester at a time using round-robin, forwards that requester's operation, address and line data, and returns the next-level response to the winner only. It also blocks new grants while the next level signals an eviction, and aborts a transaction that exceeds TIMEOUT cycles.

## Interface
- NREQ, 2: number of requesters (2..8)
- ADDRWIDTH, 32: address width
- LINEBITS, 512: line data width
- TIMEOUT, 255: maximum GRANT cycles without nl_valid (1..65535)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- op  in  NREQ×2  per-requester cachepkg operation (NOP/READ/WRITE/RFO)
- addr  in  NREQ×ADDRWIDTH  per-requester line address
- wdata  in  NREQ×LINEBITS  per-requester write line
- grant  out  NREQ  one-hot current owner, registered
- valid_out  out  NREQ  one-cycle completion pulse to owner
- rdata  out  LINEBITS  read line, registered, shared by all requesters
- timeout_err  out  1  one-cycle pulse on aborted transaction
- evict_out  out  1  combinational copy of nl_evict
- busy  out  1  high in any state except IDLE
- nl_request  out  1  request to next level
- nl_operation  out  2  forwarded op (NOP when idle)
- nl_addr  out  ADDRWIDTH  forwarded address (0 when idle)
- nl_wdata  out  LINEBITS  forwarded line (0 when idle)
- nl_valid  in  1  next-level completion
- nl_rdata  in  LINEBITS  next-level read line
- nl_evict  in  1  next-level eviction in progress

## Operation
- States: IDLE, GRANT, DONE.
- IDLE: no grant when nl_evict=1. Otherwise, if any req is high, pick the first requester with req high, searching from ptr upward with wrap-around. Load grant, clear the timer, go to GRANT. If no req is high, stay in IDLE.
- GRANT: nl_request=1. nl_operation/nl_addr/nl_wdata are driven combinationally from the granted requester's inputs. The timer counts cycles spent in GRANT.
  - nl_valid=1: latch nl_rdata into rdata and go to DONE.
  - Timer reaches TIMEOUT with nl_valid=0: load rdata=0, set an abort flag, go to DONE.
  - nl_evict during GRANT does not abort the transaction.
- DONE: valid_out[owner]=1 for exactly one cycle, with timeout_err=abort flag. ptr ← owner+1 mod NREQ. Clear grant, return to IDLE.
- Requesters must drop req in the cycle valid_out is seen. A req still high in IDLE is treated as a new request.
- req dropping during GRANT is ignored; the transaction completes.
- Reset, asynchronous and valid mid-transaction:
  - state=IDLE, ptr=0.
  - grant=0, valid_out=0, rdata=0, timeout_err=0, busy=0.
  - nl_request=0, nl_operation=NOP, nl_addr=0, nl_wdata=0.
- Timer width is $clog2(TIMEOUT+1); it never wraps.

## Timing
- Cycle 0: req sampled in IDLE. Cycle 1: grant and nl_request are high.
- nl_valid in cycle k ≥ 1 gives valid_out/rdata in cycle k+1 (DONE). Cycle k+2 is IDLE, where the next grant is decided; it becomes visible in cycle k+3.
- Minimum service time, request to valid_out, is 2 cycles. Back-to-back grants are spaced 3 cycles apart at minimum.
- Abort: with nl_valid never asserted, timeout_err and valid_out pulse in cycle TIMEOUT+1.
- evict_out has zero latency from nl_evict.

## Test plan
- Single READ: req[0]=1, op=READ, addr=0x0000_1040; nl_valid at cycle 3 with nl_rdata=0xA5…A5.
  - Required: grant=01 from cycle 1, nl_addr=0x0000_1040, valid_out[0] and rdata=0xA5…A5 at cycle 4, busy=0 at cycle 5.
- Contention and fairness: req=11 held continuously, nl_valid returned 1 cycle after each nl_request rise.
  - Required: grants alternate 01,10,01,10. Neither requester is granted twice in a row.
- Eviction block: nl_evict=1 for cycles 0–4 while req[1]=1.
  - Required: grant=0 and evict_out=1 through cycle 4; grant=10 in cycle 6.
- Timeout: TIMEOUT=8, req[0]=1, nl_valid held 0.
  - Required: valid_out[0]=1, timeout_err=1, rdata=0 at cycle 9; IDLE at cycle 10.
- Reset mid-transaction: assert reset low in cycle 2 of GRANT for requester 1.
  - Required: nl_request=0, grant=0, nl_operation=NOP immediately (asynchronous).
  - Required: after release with req=11, the first grant is 01 (ptr=0).
- Write forward: req[1]=1, op=WRITE, wdata=0x1234…, with req[0] dropping mid-GRANT.
  - Required: nl_operation=WRITE, nl_wdata=0x1234… for the whole GRANT; only valid_out[1] pulses.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bundle between the upstream cache controllers, the arbiter and the shared next-level port.
// The arbiter connects through the slave modport; whatever drives the requesters uses master.
interface cache_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int ADDRWIDTH = 32,
    parameter int LINEBITS  = 512
);
    logic [NREQ-1:0]                req;
    logic [NREQ-1:0][1:0]           op;
    logic [NREQ-1:0][ADDRWIDTH-1:0] addr;
    logic [NREQ-1:0][LINEBITS-1:0]  wdata;
    logic [NREQ-1:0]                grant;
    logic [NREQ-1:0]                valid_out;
    logic [LINEBITS-1:0]            rdata;
    logic                           timeout_err;
    logic                           evict_out;
    logic                           busy;
    logic                           nl_request;
    logic [1:0]                     nl_operation;
    logic [ADDRWIDTH-1:0]           nl_addr;
    logic [LINEBITS-1:0]            nl_wdata;
    logic                           nl_valid;
    logic [LINEBITS-1:0]            nl_rdata;
    logic                           nl_evict;

    modport slave (
        input  req, op, addr, wdata, nl_valid, nl_rdata, nl_evict,
        output grant, valid_out, rdata, timeout_err, evict_out, busy,
               nl_request, nl_operation, nl_addr, nl_wdata
    );

    modport master (
        output req, op, addr, wdata, nl_valid, nl_rdata, nl_evict,
        input  grant, valid_out, rdata, timeout_err, evict_out, busy,
               nl_request, nl_operation, nl_addr, nl_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one next-level cache port between NREQ cache controllers,
// with eviction blocking of new grants and a per-transaction timeout abort.
module cache_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDRWIDTH = 32,
    parameter int LINEBITS  = 512,
    parameter int TIMEOUT   = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    cache_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_NOP = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, owner_q, pick_idx;
    logic [TW-1:0]        timer_q;
    logic [NREQ-1:0]      grant_q, valid_out_q;
    logic [LINEBITS-1:0]  rdata_q;
    logic                 timeout_err_q;
    logic                 start, finish_ok, finish_abort;
    logic [ADDRWIDTH-1:0] fwd_addr;

    // The timer holds at TIMEOUT instead of wrapping.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TW'(TIMEOUT)) ? v : v + 1'b1;
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Walk offsets from the far end so the nearest requester at or after ptr wins.
    always_comb begin
        pick_idx = ptr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[(int'(ptr_q) + i) % NREQ]) pick_idx = PW'((int'(ptr_q) + i) % NREQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        start            = 1'b0;
        finish_ok        = 1'b0;
        finish_abort     = 1'b0;
        bus.nl_request   = 1'b0;
        bus.nl_operation = OP_NOP;
        fwd_addr         = '0;
        bus.nl_wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (!bus.nl_evict && (|bus.req)) begin
                    start   = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                bus.nl_request   = 1'b1;
                bus.nl_operation = bus.op[owner_q];
                fwd_addr         = bus.addr[owner_q];
                bus.nl_wdata     = bus.wdata[owner_q];
                // A completion in the last allowed cycle still counts as success.
                if (bus.nl_valid) begin
                    finish_ok = 1'b1;
                    state_d   = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    finish_abort = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            owner_q       <= '0;
            timer_q       <= '0;
            grant_q       <= '0;
            valid_out_q   <= '0;
            rdata_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            valid_out_q   <= '0;
            timeout_err_q <= 1'b0;
            if (start) begin
                owner_q <= pick_idx;
                grant_q <= onehot(pick_idx);
                timer_q <= '0;
            end else if (state_q == S_GRANT) begin
                timer_q <= sat_inc(timer_q);
            end
            if (finish_ok || finish_abort) begin
                valid_out_q   <= grant_q;
                timeout_err_q <= finish_abort;
                rdata_q       <= finish_ok ? bus.nl_rdata : '0;
            end
            if (state_q == S_DONE) begin
                grant_q <= '0;
                ptr_q   <= wrap_inc(owner_q);
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.rdata       = rdata_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.evict_out   = bus.nl_evict;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.nl_addr     = fwd_addr;
endmodule
